extio_arbiter: RTL and testbench
================================

# extio_arbiter

Shares the external-I/O window (0x4000_0000–0x4FFF_FFFF) between two bus masters and routes each transaction to one of five I/O peripherals: BOOT, UART, SPI, Ethernet and GPIO. It sits between the crossbar's ExtIO slave port and the peripheral register interfaces. It arbitrates round-robin, decodes the address, sequences one outstanding transaction at a time, and returns an error response for unmapped addresses or unresponsive peripherals.

## Interface
Parameters:
- NrMasters, 2, number of requesters (matches crossbar master count).
- NrPeriph, 5, number of peripherals; index order GPIO=0, Ethernet=1, SPI=2, UART=3, BOOT=4.
- TimeoutCycles, 1024, cycles allowed in ISSUE+WAIT before an error response; must be ≥ 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- m_req_i  in  [NrMasters]  request valid per master.
- m_addr_i  in  [NrMasters][64]  byte address.
- m_we_i  in  [NrMasters]  1 = write.
- m_wdata_i  in  [NrMasters][64]  write data.
- m_be_i  in  [NrMasters][8]  byte enables.
- m_gnt_o  out  [NrMasters]  request accepted (one-hot, single cycle).
- m_rvalid_o  out  [NrMasters]  response valid (one-hot, single cycle).
- m_rdata_o  out  64  read data, shared across masters.
- m_err_o  out  1  response error, valid with m_rvalid_o.
- p_req_o  out  [NrPeriph]  peripheral request (one-hot).
- p_addr_o, p_we_o, p_wdata_o, p_be_o  out  64/1/64/8  registered request fields, shared across peripherals.
- p_gnt_i  in  [NrPeriph]  peripheral accepted request.
- p_rvalid_i  in  [NrPeriph]  peripheral response.
- p_rdata_i  in  [NrPeriph][64]  peripheral read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any m_req_i is high, pick the winner round-robin, starting the search at rr_q.
  - Assert m_gnt_o[winner] combinationally in the same cycle.
  - Register addr, we, wdata and be; decode the target.
  - Mapped target → ISSUE. Unmapped target → RESP with err=1.
- **Decode**
  - Hit when addr[63:16] == Base[63:16] of that peripheral (all lengths are 64 KiB).
  - Bases: BOOT 0x4000_0000, UART 0x4100_0000, SPI 0x4200_0000, Ethernet 0x4300_0000, GPIO 0x4400_0000.
  - Any other address is unmapped.
- **ISSUE**
  - Hold p_req_o[t]=1 and stable p_* fields until p_gnt_i[t].
  - On p_gnt_i[t], go to WAIT.
  - If p_rvalid_i[t] arrives in the same cycle as p_gnt_i[t], capture it and go directly to RESP.
- **WAIT**
  - On p_rvalid_i[t], capture p_rdata_i[t] and set err=0, then go to RESP.
- **Timeout**
  - A counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - When it reaches TimeoutCycles-1 without completion, go to RESP with err=1 and rdata=0.
  - On timeout in ISSUE, drop p_req_o.
- **RESP**
  - One cycle: m_rvalid_o[winner]=1, m_rdata_o = captured data (0 on error), m_err_o = err.
  - Set rr_q = (winner+1) mod NrMasters, then return to IDLE.
  - A new request is not granted in RESP.
- p_rvalid_i outside WAIT (or outside ISSUE during the grant cycle) is ignored. This covers late responses after a timeout.
- Writes return rdata=0.

## Timing
- **Reset values**: all m_gnt_o, m_rvalid_o and p_req_o = 0; m_rdata_o = 0; m_err_o = 0; p_* fields = 0; rr_q = 0; state = IDLE; counter = 0.
- **Reset mid-transaction**: the transaction is abandoned with no response. Masters must reissue.
- **Minimum mapped latency**: gnt in cycle 0, p_req_o from cycle 1. With p_gnt_i in cycle 1 and p_rvalid_i in cycle 2, m_rvalid_o is in cycle 3.
- **Unmapped latency**: gnt in cycle 0, m_rvalid_o with err=1 in cycle 1.
- **Throughput**: at most one grant per 2 cycles (unmapped) or 4 cycles (mapped, zero-wait).
- **Simultaneous requests**: the master at index rr_q wins, or the next requesting index after it. The loser holds m_req_i and is served next.
- **Master obligations**: m_* request fields are sampled only in the grant cycle. A master must not drop m_req_i before m_gnt_o.

## Structure
- Peripheral bases, lengths and axi_extio_t indices come from the shared SoC package. No local copies.
- Add TimeoutCycles default (ExtIOTimeout) to the same package.
- One natural sub-module: rr_arbiter. It is combinational: requests + rr_q in, one-hot grant and index out.
- FSM, decode, counter and response registers live in extio_arbiter.

## Test plan
- **Mapped read**: master 0 reads 0x4100_0008; UART grants in 0 wait cycles and returns 0xDEAD_BEEF the next cycle → p_req_o=5'b01000, m_rvalid_o[0] 3 cycles after gnt, rdata=0xDEAD_BEEF, err=0.
- **Contention**: both masters request continuously after reset → grants alternate 0,1,0,1. After master 1 wins, master 0 wins the next simultaneous request.
- **Unmapped**: master 1 reads 0x4500_0000 → no p_req_o; m_rvalid_o[1] one cycle after gnt with err=1, rdata=0.
- **Timeout**: GPIO (0x4400_0000) never asserts p_rvalid_i, TimeoutCycles=16 → err response 16 cycles after ISSUE entry. A p_rvalid_i pulse 5 cycles later produces no m_rvalid_o.
- **Stall and write**: a write to 0x4300_0010 with be=0x0F; Ethernet holds gnt low for 7 cycles → p_* fields stable for all 8 ISSUE cycles; response err=0, rdata=0.
- **Reset during WAIT**: assert rst_ni=0 during WAIT → all outputs are 0 immediately; after release, the next request is granted to master 0.

Source files
------------

// File: rtl/extio_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// extio_arbiter_pkg
// Shared SoC definitions for the external-I/O window (0x4000_0000-0x4FFF_FFFF):
//   - axi_extio_t : peripheral index order (GPIO=0 .. BOOT=4)
//   - *Base       : peripheral base addresses, all ExtIOLength (64 KiB) long
//   - ExtIOTimeout: default cycles allowed before an error response
//   - state_t     : extio_arbiter FSM states
//   - extio_base(): base address lookup by peripheral index
// -----------------------------------------------------------------------------
package extio_arbiter_pkg;

    typedef enum logic [2:0] {
        EXTIO_GPIO = 3'd0,
        EXTIO_ETH  = 3'd1,
        EXTIO_SPI  = 3'd2,
        EXTIO_UART = 3'd3,
        EXTIO_BOOT = 3'd4
    } axi_extio_t;

    localparam int unsigned NrExtIO      = 5;
    localparam int unsigned ExtIOTimeout = 1024;

    localparam logic [63:0] ExtIOLength = 64'h0000_0000_0001_0000;
    localparam logic [63:0] BootBase    = 64'h0000_0000_4000_0000;
    localparam logic [63:0] UartBase    = 64'h0000_0000_4100_0000;
    localparam logic [63:0] SpiBase     = 64'h0000_0000_4200_0000;
    localparam logic [63:0] EthBase     = 64'h0000_0000_4300_0000;
    localparam logic [63:0] GpioBase    = 64'h0000_0000_4400_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [63:0] extio_base(input axi_extio_t idx);
        logic [63:0] base;
        base = GpioBase;
        case (idx)
            EXTIO_GPIO: base = GpioBase;
            EXTIO_ETH:  base = EthBase;
            EXTIO_SPI:  base = SpiBase;
            EXTIO_UART: base = UartBase;
            EXTIO_BOOT: base = BootBase;
            default:    base = GpioBase;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/extio_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// extio_arbiter_rr_arbiter
// Combinational round-robin picker. The search starts at i_rr and wraps, so
// the master at i_rr has top priority, then i_rr+1, and so on.
//   i_req   : request per master
//   i_rr    : index with highest priority this round
//   o_gnt   : one-hot winner
//   o_idx   : binary winner index
//   o_valid : some request was present
// -----------------------------------------------------------------------------
module extio_arbiter_rr_arbiter #(
    parameter int unsigned NrMasters = 2,
    parameter int unsigned IdxW      = 1
) (
    input  logic [NrMasters-1:0] i_req,
    input  logic [IdxW-1:0]      i_rr,
    output logic [NrMasters-1:0] o_gnt,
    output logic [IdxW-1:0]      o_idx,
    output logic                 o_valid
);

    int unsigned w_pos;
    logic        w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int unsigned off = 0; off < NrMasters; off++) begin
            // i_rr is always < NrMasters, so one subtraction wraps.
            w_pos = int'(i_rr) + off;
            if (w_pos >= NrMasters) begin
                w_pos = w_pos - NrMasters;
            end
            if (!w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = IdxW'(w_pos);
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/extio_arbiter.sv
// -----------------------------------------------------------------------------
// extio_arbiter
// Shares the external-I/O window between NrMasters masters and routes one
// transaction at a time to one of NrPeriph peripherals (index order from
// axi_extio_t). Unmapped addresses and peripherals that do not complete within
// TimeoutCycles (must be >= 2) get an error response with rdata = 0.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   m_req_i .. m_be_i      : master request fields, sampled in the grant cycle
//   m_gnt_o                : combinational one-hot grant (IDLE only)
//   m_rvalid_o, m_rdata_o,
//   m_err_o                : one-cycle registered response to the winner
//   p_req_o .. p_be_o      : registered one-hot peripheral request + fields
//   p_gnt_i, p_rvalid_i,
//   p_rdata_i              : peripheral handshake and read data
// -----------------------------------------------------------------------------
module extio_arbiter
    import extio_arbiter_pkg::*;
#(
    parameter int unsigned NrMasters     = 2,
    parameter int unsigned NrPeriph      = NrExtIO,
    parameter int unsigned TimeoutCycles = ExtIOTimeout
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NrMasters-1:0]          m_req_i,
    input  logic [NrMasters-1:0][63:0]    m_addr_i,
    input  logic [NrMasters-1:0]          m_we_i,
    input  logic [NrMasters-1:0][63:0]    m_wdata_i,
    input  logic [NrMasters-1:0][7:0]     m_be_i,
    output logic [NrMasters-1:0]          m_gnt_o,
    output logic [NrMasters-1:0]          m_rvalid_o,
    output logic [63:0]                   m_rdata_o,
    output logic                          m_err_o,
    output logic [NrPeriph-1:0]           p_req_o,
    output logic [63:0]                   p_addr_o,
    output logic                          p_we_o,
    output logic [63:0]                   p_wdata_o,
    output logic [7:0]                    p_be_o,
    input  logic [NrPeriph-1:0]           p_gnt_i,
    input  logic [NrPeriph-1:0]           p_rvalid_i,
    input  logic [NrPeriph-1:0][63:0]     p_rdata_i
);

    localparam int unsigned IdxW = (NrMasters > 1) ? $clog2(NrMasters) : 1;
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam int unsigned TgtW = $bits(axi_extio_t);

    // ---------------------------------------------------------------- state
    state_t                 r_state;
    logic [IdxW-1:0]        r_rr;
    logic [IdxW-1:0]        r_winner;
    logic [TgtW-1:0]        r_tgt;
    logic [CntW-1:0]        r_cnt;
    logic [NrPeriph-1:0]    r_preq;
    logic [63:0]            r_addr;
    logic                   r_we;
    logic [63:0]            r_wdata;
    logic [7:0]             r_be;
    logic [NrMasters-1:0]   r_rvalid;
    logic [63:0]            r_rdata;
    logic                   r_err;

    // ---------------------------------------------------------------- arbiter
    logic [NrMasters-1:0]   w_arb_gnt;
    logic [IdxW-1:0]        w_arb_idx;
    logic                   w_arb_valid;

    extio_arbiter_rr_arbiter #(
        .NrMasters (NrMasters),
        .IdxW      (IdxW)
    ) u_rr_arbiter (
        .i_req   (m_req_i),
        .i_rr    (r_rr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // ---------------------------------------------------------------- decode
    logic [63:0]            w_sel_addr;
    logic                   w_hit;
    logic [TgtW-1:0]        w_tgt;
    logic [NrPeriph-1:0]    w_tgt_oh;

    assign w_sel_addr = m_addr_i[w_arb_idx];

    always_comb begin
        w_hit    = 1'b0;
        w_tgt    = '0;
        w_tgt_oh = '0;
        for (int unsigned i = 0; i < NrPeriph; i++) begin
            if ((w_sel_addr & ~(ExtIOLength - 64'd1)) ==
                extio_base(axi_extio_t'(TgtW'(i)))) begin
                w_hit       = 1'b1;
                w_tgt       = TgtW'(i);
                w_tgt_oh    = '0;
                w_tgt_oh[i] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    logic                   w_p_gnt;
    logic                   w_p_rvalid;
    logic [63:0]            w_resp_data;
    logic                   w_timeout;
    logic [NrMasters-1:0]   w_winner_oh;
    logic [IdxW-1:0]        w_rr_next;

    assign w_p_gnt     = p_gnt_i[r_tgt];
    assign w_p_rvalid  = p_rvalid_i[r_tgt];
    // Writes always return zero data, whatever the peripheral drives.
    assign w_resp_data = r_we ? 64'd0 : p_rdata_i[r_tgt];
    assign w_timeout   = (r_cnt == CntW'(TimeoutCycles - 1));
    assign w_rr_next   = (r_winner == IdxW'(NrMasters - 1)) ? '0
                                                            : r_winner + IdxW'(1);

    always_comb begin
        w_winner_oh           = '0;
        w_winner_oh[r_winner] = 1'b1;
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_rr     <= '0;
            r_winner <= '0;
            r_tgt    <= '0;
            r_cnt    <= '0;
            r_preq   <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_addr   <= w_sel_addr;
                        r_we     <= m_we_i[w_arb_idx];
                        r_wdata  <= m_wdata_i[w_arb_idx];
                        r_be     <= m_be_i[w_arb_idx];
                        r_winner <= w_arb_idx;
                        r_tgt    <= w_tgt;
                        r_cnt    <= '0;
                        if (w_hit) begin
                            r_preq  <= w_tgt_oh;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_rvalid <= w_arb_gnt;
                            r_rdata  <= '0;
                            r_err    <= 1'b1;
                            r_state  <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= r_cnt + CntW'(1);
                    // A response alongside the grant completes immediately;
                    // a bare grant at the last allowed cycle still times out.
                    if (w_p_gnt && w_p_rvalid) begin
                        r_preq   <= '0;
                        r_rvalid <= w_winner_oh;
                        r_rdata  <= w_resp_data;
                        r_err    <= 1'b0;
                        r_state  <= ST_RESP;
                    end else if (w_timeout) begin
                        r_preq   <= '0;
                        r_rvalid <= w_winner_oh;
                        r_rdata  <= '0;
                        r_err    <= 1'b1;
                        r_state  <= ST_RESP;
                    end else if (w_p_gnt) begin
                        r_preq  <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CntW'(1);
                    if (w_p_rvalid) begin
                        r_rvalid <= w_winner_oh;
                        r_rdata  <= w_resp_data;
                        r_err    <= 1'b0;
                        r_state  <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rvalid <= w_winner_oh;
                        r_rdata  <= '0;
                        r_err    <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rr    <= w_rr_next;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    // Grant is combinational; it is masked while reset is held so that all
    // outputs read zero during reset even with requests pending.
    assign m_gnt_o    = (r_state == ST_IDLE && rst_ni) ? w_arb_gnt : '0;
    assign m_rvalid_o = r_rvalid;
    assign m_rdata_o  = r_rdata;
    assign m_err_o    = r_err;
    assign p_req_o    = r_preq;
    assign p_addr_o   = r_addr;
    assign p_we_o     = r_we;
    assign p_wdata_o  = r_wdata;
    assign p_be_o     = r_be;

endmodule

// File: tb/tb_extio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_extio_arbiter
// Scenario tasks drive masters and peripherals; expected responses are pushed
// to a scoreboard queue at request time and popped when m_rvalid_o fires.
// -----------------------------------------------------------------------------
module tb_extio_arbiter;

    localparam int NM = 2;
    localparam int NP = 5;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NM-1:0]        m_req, m_we, m_gnt, m_rvalid;
    logic [NM-1:0][63:0]  m_addr, m_wdata;
    logic [NM-1:0][7:0]   m_be;
    logic [63:0]          m_rdata;
    logic                 m_err;
    logic [NP-1:0]        p_req, p_gnt, p_rvalid;
    logic [63:0]          p_addr, p_wdata;
    logic                 p_we;
    logic [7:0]           p_be;
    logic [NP-1:0][63:0]  p_rdata;

    always #5 clk = ~clk;

    extio_arbiter #(
        .NrMasters     (NM),
        .NrPeriph      (NP),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m_req_i    (m_req),
        .m_addr_i   (m_addr),
        .m_we_i     (m_we),
        .m_wdata_i  (m_wdata),
        .m_be_i     (m_be),
        .m_gnt_o    (m_gnt),
        .m_rvalid_o (m_rvalid),
        .m_rdata_o  (m_rdata),
        .m_err_o    (m_err),
        .p_req_o    (p_req),
        .p_addr_o   (p_addr),
        .p_we_o     (p_we),
        .p_wdata_o  (p_wdata),
        .p_be_o     (p_be),
        .p_gnt_i    (p_gnt),
        .p_rvalid_i (p_rvalid),
        .p_rdata_i  (p_rdata)
    );

    typedef struct {
        logic [NM-1:0] rv;
        logic [63:0]   rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Present a request from master m and return one cycle after the grant
    // (#1 after the edge), with the master's fields scrambled afterwards.
    task automatic do_req(input int m, input logic [63:0] addr, input logic we,
                          input logic [63:0] wdata, input logic [7:0] be,
                          output bit granted);
        @(posedge clk); #1;
        m_addr[m]  = addr;
        m_we[m]    = we;
        m_wdata[m] = wdata;
        m_be[m]    = be;
        m_req[m]   = 1'b1;
        granted    = 1'b0;
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            if (m_gnt[m]) granted = 1'b1;
        end
        @(posedge clk); #1;
        m_req[m]   = 1'b0;
        m_addr[m]  = '1;
        m_wdata[m] = '1;
        m_be[m]    = '1;
        m_we[m]    = ~we;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
        p_gnt = '0; p_rvalid = '0; p_rdata = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_gnt, m_rvalid, p_req} !== '0) begin
            n_fail++;
            $display("FAIL reset_valids: got gnt=%b rvalid=%b p_req=%b, want all 0", m_gnt, m_rvalid, p_req);
        end
        n_checks++;
        if (m_rdata !== 64'd0 || m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp: got rdata=%h err=%b, want 0/0", m_rdata, m_err);
        end
        n_checks++;
        if (p_addr !== 64'd0 || p_we !== 1'b0 || p_wdata !== 64'd0 || p_be !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_pfields: got addr=%h we=%b wdata=%h be=%h, want 0", p_addr, p_we, p_wdata, p_be);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mapped_read;
        exp_t e; bit g;
        $display("mapped read: m0 rd 0x41000008 (UART)");
        sb.push_back('{2'b01, 64'h0000_0000_DEAD_BEEF, 1'b0});
        do_req(0, 64'h4100_0008, 1'b0, 64'd0, 8'hFF, g);
        n_checks++;
        if (!g) begin n_fail++; $display("FAIL mapped_gnt: got no grant, want grant"); end
        p_gnt[3] = 1'b1;                                  // cycle 1
        @(negedge clk);
        n_checks++;
        if (p_req !== 5'b01000 || p_addr !== 64'h4100_0008) begin
            n_fail++;
            $display("FAIL mapped_preq: got p_req=%b addr=%h, want 01000/4100_0008", p_req, p_addr);
        end
        @(posedge clk); #1;                               // cycle 2
        p_gnt[3] = 1'b0; p_rvalid[3] = 1'b1; p_rdata[3] = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (m_rvalid !== 2'b00 || p_req !== 5'b00000) begin
            n_fail++;
            $display("FAIL mapped_early: got rvalid=%b p_req=%b in cycle 2, want 00/00000", m_rvalid, p_req);
        end
        @(posedge clk); #1;                               // cycle 3
        p_rvalid[3] = 1'b0; p_rdata[3] = 64'h1;
        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL mapped_resp: scoreboard empty, want an entry");
        end else begin
            e = sb.pop_front();
            if (m_rvalid !== e.rv || m_rdata !== e.rdata || m_err !== e.err) begin
                n_fail++;
                $display("FAIL mapped_resp: got rv=%b rdata=%h err=%b, want rv=%b rdata=%h err=%b", m_rvalid, m_rdata, m_err, e.rv, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_contention;
        exp_t e; logic [NM-1:0] want;
        $display("contention: both masters continuous, unmapped");
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        m_addr[0] = 64'h4500_0000; m_addr[1] = 64'h4800_0000;
        m_we = '0; m_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_checks++;
            if (m_gnt !== want) begin
                n_fail++; $display("FAIL contention_gnt%0d: got %b, want %b", k, m_gnt, want);
            end
            sb.push_back('{want, 64'd0, 1'b1});
            @(negedge clk);
            n_checks++;
            e = sb.pop_front();
            if (m_rvalid !== e.rv || m_rdata !== e.rdata || m_err !== e.err || m_gnt !== 2'b00) begin
                n_fail++;
                $display("FAIL contention_resp%0d: got rv=%b rdata=%h err=%b gnt=%b, want rv=%b rdata=0 err=1 gnt=00", k, m_rvalid, m_rdata, m_err, m_gnt, e.rv);
            end
        end
        @(posedge clk); #1; m_req = '0;
    endtask

    task automatic test_unmapped;
        exp_t e; bit g;
        $display("unmapped: m1 rd 0x45000000");
        p_rdata = {NP{64'hA5A5_A5A5_A5A5_A5A5}};
        sb.push_back('{2'b10, 64'd0, 1'b1});
        do_req(1, 64'h4500_0000, 1'b0, 64'd0, 8'hFF, g);
        n_checks++;
        if (!g) begin n_fail++; $display("FAIL unmapped_gnt: got no grant, want grant"); end
        @(negedge clk);
        n_checks++;
        e = sb.pop_front();
        if (m_rvalid !== e.rv || m_rdata !== e.rdata || m_err !== e.err || p_req !== 5'b0) begin
            n_fail++;
            $display("FAIL unmapped_resp: got rv=%b rdata=%h err=%b p_req=%b, want rv=%b rdata=0 err=1 p_req=0", m_rvalid, m_rdata, m_err, p_req, e.rv);
        end
        p_rdata = '0;
    endtask

    task automatic test_timeout;
        exp_t e; bit g; bit early; bit spurious;
        $display("timeout: m0 rd 0x44000000 (GPIO), no response");
        sb.push_back('{2'b01, 64'd0, 1'b1});
        do_req(0, 64'h4400_0000, 1'b0, 64'd0, 8'hFF, g);
        n_checks++;
        if (!g) begin n_fail++; $display("FAIL timeout_gnt: got no grant, want grant"); end
        early = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            p_gnt[0] = (c == 3);
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (p_req !== 5'b00001) begin
                    n_fail++; $display("FAIL timeout_preq: got %b, want 00001", p_req);
                end
            end
            if (m_rvalid !== 2'b00) early = 1'b1;
            @(posedge clk); #1;
        end
        p_gnt[0] = 1'b0;
        n_checks++;
        if (early) begin n_fail++; $display("FAIL timeout_early: got response before cycle %0d, want none", TO + 1); end
        @(negedge clk);
        n_checks++;
        e = sb.pop_front();
        if (m_rvalid !== e.rv || m_rdata !== e.rdata || m_err !== e.err || p_req !== 5'b0) begin
            n_fail++;
            $display("FAIL timeout_resp: got rv=%b rdata=%h err=%b p_req=%b, want rv=%b rdata=0 err=1", m_rvalid, m_rdata, m_err, p_req, e.rv);
        end
        repeat (5) @(posedge clk);
        #1; p_rvalid[0] = 1'b1; p_rdata[0] = 64'hBAD;
        @(posedge clk); #1; p_rvalid[0] = 1'b0; p_rdata[0] = '0;
        spurious = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (m_rvalid !== 2'b00) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) begin n_fail++; $display("FAIL timeout_late: got m_rvalid from late p_rvalid, want none"); end
    endtask

    task automatic test_stall_write;
        exp_t e; bit g; bit early;
        $display("stall+write: m1 wr 0x43000010 be=0F (ETH), 7 stall cycles");
        p_rdata[1] = 64'hFFFF_0000_1234_5678;
        sb.push_back('{2'b10, 64'd0, 1'b0});
        do_req(1, 64'h4300_0010, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, g);
        n_checks++;
        if (!g) begin n_fail++; $display("FAIL stall_gnt: got no grant, want grant"); end
        early = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            p_gnt[1]    = (c == 8);
            p_rvalid[1] = (c == 8);
            @(negedge clk);
            n_checks++;
            if (p_req !== 5'b00010 || p_addr !== 64'h4300_0010 || p_we !== 1'b1 ||
                p_wdata !== 64'h1122_3344_5566_7788 || p_be !== 8'h0F) begin
                n_fail++;
                $display("FAIL stall_fields_c%0d: got req=%b addr=%h we=%b wdata=%h be=%h, want 00010/4300_0010/1/1122334455667788/0f", c, p_req, p_addr, p_we, p_wdata, p_be);
            end
            if (m_rvalid !== 2'b00) early = 1'b1;
            @(posedge clk); #1;
        end
        p_gnt[1] = 1'b0; p_rvalid[1] = 1'b0; p_rdata[1] = '0;
        n_checks++;
        if (early) begin n_fail++; $display("FAIL stall_early: got response during ISSUE, want none"); end
        @(negedge clk);
        n_checks++;
        e = sb.pop_front();
        if (m_rvalid !== e.rv || m_rdata !== e.rdata || m_err !== e.err) begin
            n_fail++;
            $display("FAIL stall_resp: got rv=%b rdata=%h err=%b, want rv=%b rdata=0 err=0", m_rvalid, m_rdata, m_err, e.rv);
        end
    endtask

    task automatic test_reset_wait;
        exp_t e; bit g;
        $display("reset during WAIT: m0 unmapped, m1 rd UART, reset, both request");
        sb.push_back('{2'b01, 64'd0, 1'b1});
        do_req(0, 64'h4600_0000, 1'b0, 64'd0, 8'hFF, g);
        @(negedge clk);
        n_checks++;
        e = sb.pop_front();
        if (!g || m_rvalid !== e.rv || m_err !== e.err) begin
            n_fail++; $display("FAIL rstwait_pre: got gnt_ok=%b rv=%b err=%b, want 1/%b/1", g, m_rvalid, m_err, e.rv);
        end
        do_req(1, 64'h4100_0000, 1'b0, 64'd0, 8'hFF, g);
        p_gnt[3] = 1'b1;                                   // ISSUE -> WAIT
        @(posedge clk); #1;
        p_gnt[3] = 1'b0;
        m_addr[0] = 64'h4700_0000; m_addr[1] = 64'h4700_0008; m_we = '0;
        m_req = 2'b11;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_gnt, m_rvalid, p_req} !== '0 || m_rdata !== 64'd0 || m_err !== 1'b0 || p_addr !== 64'd0) begin
            n_fail++;
            $display("FAIL rstwait_outs: got gnt=%b rv=%b p_req=%b rdata=%h err=%b p_addr=%h, want all 0", m_gnt, m_rvalid, p_req, m_rdata, m_err, p_addr);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++;
        if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL rstwait_gnt0: got %b, want 01", m_gnt); end
        sb.push_back('{2'b01, 64'd0, 1'b1});
        @(posedge clk); #1; m_req[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        e = sb.pop_front();
        if (m_rvalid !== e.rv || m_rdata !== e.rdata || m_err !== e.err) begin
            n_fail++; $display("FAIL rstwait_resp0: got rv=%b rdata=%h err=%b, want %b/0/1", m_rvalid, m_rdata, m_err, e.rv);
        end
        sb.push_back('{2'b10, 64'd0, 1'b1});
        @(negedge clk);
        n_checks++;
        if (m_gnt !== 2'b10) begin n_fail++; $display("FAIL rstwait_gnt1: got %b, want 10", m_gnt); end
        @(posedge clk); #1; m_req[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        e = sb.pop_front();
        if (m_rvalid !== e.rv || m_rdata !== e.rdata || m_err !== e.err) begin
            n_fail++; $display("FAIL rstwait_resp1: got rv=%b rdata=%h err=%b, want %b/0/1", m_rvalid, m_rdata, m_err, e.rv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mapped_read();
        test_contention();
        test_unmapped();
        test_timeout();
        test_stall_write();
        test_reset_wait();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d pending responses, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
